mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port synchronous block RAM (64 x 16 in the default build) between the CPU and a secondary master, such as the keyboard/monitor DMA path. It serialises accesses and presents the RAM timing to the winner through a req/ack handshake. It selects between requesters round-robin, or with fixed priority for master 0. It sits inside `top`, between the masters and the RAM instance.

## Interface
- ADDR_WIDTH, 6: RAM address width.
- DATA_WIDTH, 16: RAM data width.
- FIXED_PRIO, 0: 0 = round-robin; 1 = master 0 always wins ties.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  access request; held until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req is high.
- m0_addr, m1_addr  in  ADDR_WIDTH  address; stable while req is high.
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data; stable while req is high.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data, valid while ack is high; held afterwards.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data; registered, valid one cycle after the address.

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- Reset values:
  - state = IDLE.
  - mem_addr, mem_we, mem_wdata = 0.
  - both acks = 0; both rdata = 0.
  - last-grant pointer = 1, so master 0 is favoured first.
- IDLE:
  - A master is eligible if req = 1 and its ack is currently 0. The ack mask prevents a double grant on a stale req.
  - No eligible master: stay in IDLE; mem_we = 0.
  - One eligible master: grant it.
  - Both eligible, FIXED_PRIO = 0: grant the master not equal to the last-grant pointer.
  - Both eligible, FIXED_PRIO = 1: grant master 0.
  - On grant:
    - latch sel;
    - load mem_addr, mem_we and mem_wdata from the winner;
    - update the pointer to the winner;
    - go to ACCESS.
- ACCESS:
  - RAM sees address and write enable for exactly one cycle.
  - On exit: mem_we <= 0; go to RESP.
- RESP:
  - mem_rdata is valid.
  - Capture it into rdata of master sel, for reads and writes alike. A write therefore returns the RAM's read-during-write value, which is don't-care to masters.
  - Pulse ack of master sel (high during the next cycle).
  - Go to IDLE.
  - The other master's rdata and ack are untouched.
- Master contract:
  - Deassert req, or present a new request, on the edge after ack is seen.
  - A request held across the ack cycle is masked for that one IDLE cycle only.
- mem_addr and mem_wdata hold their last value outside ACCESS. Only mem_we is forced low.
- Reset in any state:
  - return to IDLE next edge;
  - mem_we = 0;
  - the in-flight access is dropped with no ack;
  - the pointer is reset.

## Timing
- Request first seen in IDLE at edge N:
  - mem_* are driven during cycle N..N+1;
  - the write commits at edge N+1;
  - ack and rdata are high/valid during N+2..N+3.
- Latency from the sampling edge to ack: 2 cycles.
- Back-to-back throughput: one access per 3 cycles when the other master is waiting. A single master re-requesting gets one access per 4 cycles, because of the ack mask.
- Round-robin bound: with both masters continuously requesting, grants alternate 0,1,0,1. The worst-case wait is one foreign access (3 cycles) plus own access.
- Requests arriving in ACCESS or RESP are ignored until IDLE; no requests are queued.
- At most one ack is high in any cycle.

## Test plan
- Reset then idle: rst high 2 cycles, no reqs → all outputs 0; no ack for 20 cycles.
- Single write/read, master 0: write 0x1234 @ 0x05, then read @ 0x05 → mem_we high exactly 1 cycle; m0_ack 2 cycles after sampling; m0_rdata = 0x1234; m1_ack never asserts.
- Simultaneous requests, FIXED_PRIO = 0, both held:
  - m0 reads 0x01 (preloaded 0xAAAA); m1 reads 0x02 (0x5555).
  - Expected order: m0 ack first, then m1. Continued requests alternate 0,1,0,1.
  - Data routed correctly; never both acks in one cycle.
- FIXED_PRIO = 1, both requesting continuously → m0 granted on every IDLE where eligible. m1 is granted only in the IDLE cycles where m0 is masked after its ack.
- Collision data integrity: m0 writes 0xBEEF @ 0x3F (top address) while m1 simultaneously reads 0x3F → read returns the old value if m1 wins first, 0xBEEF if m0 wins first. Result consistent with grant order.
- Reset mid-access: assert rst during ACCESS of a write → no ack is generated; state returns to IDLE. The next request from master 0 is granted first, with normal 2-cycle latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between two masters.
// Accesses are serialised through a req/ack handshake; selection is round-robin or master-0 priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  sel_reg, sel_next;
  logic                  ptr_reg, ptr_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic                  mem_we_reg, mem_we_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [1:0]            ack_reg, ack_next;
  logic [1:0]            capture;
  logic [1:0]            req_vec, we_vec, elig;
  logic [ADDR_WIDTH-1:0] addr_arr  [2];
  logic [DATA_WIDTH-1:0] wdata_arr [2];
  logic [DATA_WIDTH-1:0] rdata_arr [2];
  logic                  grant_valid, grant;

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  // A master whose ack is high right now is masked so its stale req is not granted twice.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      logic [DATA_WIDTH-1:0] rdata_reg;

      assign elig[gi] = req_vec[gi] & ~ack_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (capture[gi]) begin
          rdata_reg <= mem_rdata;
        end
      end

      assign rdata_arr[gi] = rdata_reg;
    end
  endgenerate

  always_comb begin
    grant_valid = |elig;
    if (elig == 2'b11) begin
      grant = (FIXED_PRIO != 0) ? 1'b0 : ~ptr_reg;
    end else begin
      grant = elig[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      ptr_reg       <= 1'b1;
      mem_addr_reg  <= '0;
      mem_we_reg    <= 1'b0;
      mem_wdata_reg <= '0;
      ack_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      ptr_reg       <= ptr_next;
      mem_addr_reg  <= mem_addr_next;
      mem_we_reg    <= mem_we_next;
      mem_wdata_reg <= mem_wdata_next;
      ack_reg       <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    state_next = grant_valid ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address and write data hold between accesses; only the write enable is forced low.
  always_comb begin
    sel_next       = sel_reg;
    ptr_next       = ptr_reg;
    mem_addr_next  = mem_addr_reg;
    mem_we_next    = 1'b0;
    mem_wdata_next = mem_wdata_reg;
    ack_next       = '0;
    capture        = '0;
    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          sel_next       = grant;
          ptr_next       = grant;
          mem_addr_next  = addr_arr[grant];
          mem_we_next    = we_vec[grant];
          mem_wdata_next = wdata_arr[grant];
        end
      end
      ACCESS: begin
        mem_we_next = 1'b0;
      end
      RESP: begin
        ack_next[sel_reg] = 1'b1;
        capture[sel_reg]  = 1'b1;
      end
      default: begin
        mem_we_next = 1'b0;
      end
    endcase
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_we    = mem_we_reg;
  assign mem_wdata = mem_wdata_reg;
  assign m0_ack    = ack_reg[0];
  assign m1_ack    = ack_reg[1];
  assign m0_rdata  = rdata_arr[0];
  assign m1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance, each with its own RAM model.
// Single transactions come from a vector table; arbitration corners are driven as hand sequences.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_rr [2];
  logic          req_fp [2];
  logic          m_we   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];

  logic          rr_ack0, rr_ack1, fp_ack0, fp_ack1;
  logic [DW-1:0] rr_rd0, rr_rd1, fp_rd0, fp_rd1;
  logic [AW-1:0] rr_mem_addr, fp_mem_addr;
  logic          rr_mem_we, fp_mem_we;
  logic [DW-1:0] rr_mem_wdata, fp_mem_wdata, rr_mem_rdata, fp_mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(req_rr[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_ack(rr_ack0), .m0_rdata(rr_rd0),
    .m1_req(req_rr[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_ack(rr_ack1), .m1_rdata(rr_rd1),
    .mem_addr(rr_mem_addr), .mem_we(rr_mem_we), .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_req(req_fp[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_ack(fp_ack0), .m0_rdata(fp_rd0),
    .m1_req(req_fp[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_ack(fp_ack1), .m1_rdata(fp_rd1),
    .mem_addr(fp_mem_addr), .mem_we(fp_mem_we), .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
  );

  // Single-port RAMs with registered, read-first output
  logic [DW-1:0] ram_rr [64];
  logic [DW-1:0] ram_fp [64];
  always_ff @(posedge clk) begin
    if (rr_mem_we) ram_rr[rr_mem_addr] <= rr_mem_wdata;
    rr_mem_rdata <= ram_rr[rr_mem_addr];
    if (fp_mem_we) ram_fp[fp_mem_addr] <= fp_mem_wdata;
    fp_mem_rdata <= ram_fp[fp_mem_addr];
  end

  typedef struct {
    int          m;
    logic        chk;
    logic [DW-1:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int            m;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[8];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic ack_of(input logic fp, input int m);
    if (fp) return (m == 0) ? fp_ack0 : fp_ack1;
    return (m == 0) ? rr_ack0 : rr_ack1;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input logic fp, input int m);
    if (fp) return (m == 0) ? fp_rd0 : fp_rd1;
    return (m == 0) ? rr_rd0 : rr_rd1;
  endfunction

  task automatic set_req(input logic fp, input int m, input logic v);
    if (fp) req_fp[m] = v;
    else req_rr[m] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_rr[m] = 1'b0;
      req_fp[m] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One master alone: ack exactly 3 edges after the drive (sampling edge + 2).
  task automatic run_txn(input logic fp, input int m, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic chk, input logic [DW-1:0] exp,
                         input string tag);
    int   cyc = 0;
    int   we_cyc = 0;
    int   foreign = 0;
    logic got = 1'b0;
    sb_t  e;
    @(negedge clk);
    m_we[m] = we; m_addr[m] = addr; m_wdata[m] = wdata;
    set_req(fp, m, 1'b1);
    e.m = m; e.chk = chk; e.exp = exp;
    sb_q.push_back(e);
    while (!got && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
      if (fp ? fp_mem_we : rr_mem_we) we_cyc++;
      if (ack_of(fp, 1 - m)) foreign++;
      if (ack_of(fp, m)) got = 1'b1;
    end
    check({tag, "_latency"}, cyc, 3);
    check({tag, "_we_pulse"}, we_cyc, we ? 1 : 0);
    check({tag, "_foreign_ack"}, foreign, 0);
    if (got) begin
      e = sb_q.pop_front();
      if (e.chk) check({tag, "_rdata"}, rdata_of(fp, m), e.exp);
    end else begin
      void'(sb_q.pop_back());
    end
    $display("txn %s: m%0d %s addr=0x%02h wdata=0x%04h rdata=0x%04h edges=%0d",
             tag, m, we ? "W" : "R", addr, wdata, rdata_of(fp, m), cyc);
    @(negedge clk);
    set_req(fp, m, 1'b0);
  endtask

  // Both masters request together, each for 'rounds' accesses; grants must alternate from 'first'.
  task automatic run_pair(input logic fp, input int rounds, input int first,
                          input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic c0, input logic [DW-1:0] e0,
                          input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                          input logic c1, input logic [DW-1:0] e1, input string tag);
    int  left[2];
    int  cyc = 0;
    int  seen = 0;
    int  both = 0;
    sb_t e;
    @(negedge clk);
    m_we[0] = w0; m_addr[0] = a0; m_wdata[0] = d0;
    m_we[1] = w1; m_addr[1] = a1; m_wdata[1] = d1;
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 2; k++) begin
        e.m   = (k == 0) ? first : 1 - first;
        e.chk = (e.m == 0) ? c0 : c1;
        e.exp = (e.m == 0) ? e0 : e1;
        sb_q.push_back(e);
      end
    end
    left[0] = rounds;
    left[1] = rounds;
    set_req(fp, 0, 1'b1);
    set_req(fp, 1, 1'b1);
    while (seen < 2 * rounds && cyc < 8 * rounds) begin
      @(posedge clk); #1;
      cyc++;
      if (ack_of(fp, 0) && ack_of(fp, 1)) both++;
      for (int m = 0; m < 2; m++) begin
        if (ack_of(fp, m)) begin
          seen++;
          left[m]--;
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_order"}, m, e.m);
            if (e.chk && e.m == m) check({tag, "_rdata"}, rdata_of(fp, m), e.exp);
          end
          $display("txn %s: ack m%0d edge=%0d rdata=0x%04h", tag, m, cyc, rdata_of(fp, m));
        end
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) if (left[m] <= 0) set_req(fp, m, 1'b0);
    end
    check({tag, "_ack_count"}, seen, 2 * rounds);
    check({tag, "_cycles"}, cyc, 6 * rounds);
    check({tag, "_double_ack"}, both, 0);
    set_req(fp, 0, 1'b0);
    set_req(fp, 1, 1'b0);
    sb_q.delete();
  endtask

  initial begin
    int acks;
    int wes;

    vecs[0] = '{m: 0, we: 1'b1, addr: 6'h05, wdata: 16'h1234, chk: 1'b0, exp: 16'h0000};
    vecs[1] = '{m: 0, we: 1'b0, addr: 6'h05, wdata: 16'h0000, chk: 1'b1, exp: 16'h1234};
    vecs[2] = '{m: 0, we: 1'b1, addr: 6'h01, wdata: 16'hAAAA, chk: 1'b0, exp: 16'h0000};
    vecs[3] = '{m: 1, we: 1'b1, addr: 6'h02, wdata: 16'h5555, chk: 1'b0, exp: 16'h0000};
    vecs[4] = '{m: 1, we: 1'b0, addr: 6'h01, wdata: 16'h0000, chk: 1'b1, exp: 16'hAAAA};
    vecs[5] = '{m: 0, we: 1'b0, addr: 6'h02, wdata: 16'h0000, chk: 1'b1, exp: 16'h5555};
    vecs[6] = '{m: 1, we: 1'b1, addr: 6'h3F, wdata: 16'h0F0F, chk: 1'b0, exp: 16'h0000};
    vecs[7] = '{m: 0, we: 1'b0, addr: 6'h3F, wdata: 16'h0000, chk: 1'b1, exp: 16'h0F0F};

    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_rr[m] = 1'b0; req_fp[m] = 1'b0;
      m_we[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_m0_ack", rr_ack0, 0);
    check("reset_m1_ack", rr_ack1, 0);
    check("reset_m0_rdata", rr_rd0, 0);
    check("reset_m1_rdata", rr_rd1, 0);
    check("reset_mem_addr", rr_mem_addr, 0);
    check("reset_mem_we", rr_mem_we, 0);
    check("reset_mem_wdata", rr_mem_wdata, 0);
    acks = 0; wes = 0;
    repeat (20) begin
      @(posedge clk); #1;
      acks += rr_ack0 + rr_ack1 + fp_ack0 + fp_ack1;
      wes  += rr_mem_we + fp_mem_we;
    end
    check("idle_no_ack", acks, 0);
    check("idle_no_we", wes, 0);

    for (int i = 0; i < 8; i++)
      run_txn(1'b0, vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));

    do_reset();
    run_pair(1'b0, 3, 0, 1'b0, 6'h01, 16'h0, 1'b1, 16'hAAAA,
             1'b0, 6'h02, 16'h0, 1'b1, 16'h5555, "rr_alternate");

    run_pair(1'b0, 1, 0, 1'b1, 6'h3F, 16'hBEEF, 1'b0, 16'h0,
             1'b0, 6'h3F, 16'h0, 1'b1, 16'hBEEF, "collide_m0_first");
    run_txn(1'b0, 0, 1'b0, 6'h3F, 16'h0, 1'b1, 16'hBEEF, "collide_a_verify");
    run_pair(1'b0, 1, 1, 1'b1, 6'h3F, 16'hCAFE, 1'b0, 16'h0,
             1'b0, 6'h3F, 16'h0, 1'b1, 16'hBEEF, "collide_m1_first");
    run_txn(1'b0, 1, 1'b0, 6'h3F, 16'h0, 1'b1, 16'hCAFE, "collide_b_verify");

    run_txn(1'b1, 0, 1'b1, 6'h10, 16'h1111, 1'b0, 16'h0, "fp_prep");
    run_pair(1'b1, 2, 0, 1'b0, 6'h10, 16'h0, 1'b1, 16'h1111,
             1'b0, 6'h10, 16'h0, 1'b1, 16'h1111, "fixed_prio");

    @(negedge clk);
    m_we[0] = 1'b1; m_addr[0] = 6'h07; m_wdata[0] = 16'h7777;
    req_rr[0] = 1'b1;
    @(posedge clk); #1;
    check("midrst_access_we", rr_mem_we, 1);
    rst = 1'b1;
    req_rr[0] = 1'b0;
    @(posedge clk); #1;
    check("midrst_we_low", rr_mem_we, 0);
    check("midrst_m0_rdata", rr_rd0, 0);
    check("midrst_mem_addr", rr_mem_addr, 0);
    rst = 1'b0;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      acks += rr_ack0 + rr_ack1;
    end
    check("midrst_no_ack", acks, 0);
    $display("txn midrst: write @0x07 dropped by reset, acks=%0d", acks);
    run_pair(1'b0, 1, 0, 1'b0, 6'h05, 16'h0, 1'b1, 16'h1234,
             1'b0, 6'h01, 16'h0, 1'b1, 16'hAAAA, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
